// File: rtl/phase_sequencer_if.sv
// Handshake bundle between decoder/memory and the instruction phase sequencer.
// The master side drives the request/acknowledge flags; the slave side is the sequencer.
interface phase_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic             run;
  logic             halt_req;
  logic             need_mem;
  logic             mem_ready;
  logic [4:0]       phase;
  logic             ir_we;
  logic             pc_we;
  logic             halted;
  logic             err;
  logic [CNT_W-1:0] retired;

  modport master (
    output run, halt_req, need_mem, mem_ready,
    input  phase, ir_we, pc_we, halted, err, retired
  );

  modport slave (
    input  run, halt_req, need_mem, mem_ready,
    output phase, ir_we, pc_we, halted, err, retired
  );
endinterface

// File: rtl/phase_sequencer.sv
// One-hot instruction phase sequencer (F,R,X,M,W) with memory-wait stretching,
// memory-phase skipping, HALT stop and memory timeout flag. WAIT_MAX must be 1..255.
module phase_sequencer #(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 16
) (
  input logic              clk,
  input logic              rst,
  phase_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_F,
    S_R,
    S_X,
    S_M,
    S_W,
    S_HALT
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_wait;
  logic [7:0]       w_wait_next;
  logic [4:0]       r_phase;
  logic             r_err;
  logic [CNT_W-1:0] r_retired;
  logic             w_timeout;
  logic             w_ir_we;
  logic             w_pc_we;

  function automatic logic [4:0] phase_of(input state_t s);
    case (s)
      S_F:     return 5'b00001;
      S_R:     return 5'b00010;
      S_X:     return 5'b00100;
      S_M:     return 5'b01000;
      S_W:     return 5'b10000;
      default: return 5'b00000;
    endcase
  endfunction

  always_comb begin
    w_next      = r_state;
    w_wait_next = r_wait;
    w_timeout   = 1'b0;
    w_ir_we     = 1'b0;
    w_pc_we     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.run) begin
          w_next      = S_F;
          w_wait_next = '0;
        end
      end
      // F and M share the wait/timeout rule; only the exit target and ir_we differ
      S_F, S_M: begin
        if (bus.mem_ready) begin
          if (r_state == S_F) begin
            w_next  = S_R;
            w_ir_we = 1'b1;
          end else begin
            w_next = S_W;
          end
        end else if (r_wait == WAIT_LAST) begin
          w_next    = S_HALT;
          w_timeout = 1'b1;
        end else begin
          w_wait_next = r_wait + 8'd1;
        end
      end
      S_R: begin
        if (bus.halt_req) begin
          w_next = S_HALT;
        end else begin
          w_next = S_X;
        end
      end
      S_X: begin
        w_wait_next = '0;
        if (bus.need_mem) begin
          w_next = S_M;
        end else begin
          w_next = S_W;
        end
      end
      S_W: begin
        w_next      = S_F;
        w_wait_next = '0;
        w_pc_we     = 1'b1;
      end
      S_HALT: begin
        w_next = S_HALT;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Phase is registered from the next state so it always matches r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_wait    <= '0;
      r_phase   <= '0;
      r_err     <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_wait_next;
      r_phase <= phase_of(w_next);
      if (w_timeout) begin
        r_err <= 1'b1;
      end
      if (w_pc_we) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  assign bus.phase   = r_phase;
  assign bus.ir_we   = w_ir_we & ~rst;
  assign bus.pc_we   = w_pc_we & ~rst;
  assign bus.halted  = (r_state == S_HALT);
  assign bus.err     = r_err;
  assign bus.retired = r_retired;

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Generates the one-hot instruction phase vector (fetch, read, execute, memory, write-back) that drives the memory-address selector and the rest of the datapath.
- Sits directly upstream of the PC/DR address selector.
- Sequences one instruction at a time and stretches the fetch and memory phases until memory acknowledges.
- Skips the memory phase for instructions that do not need it, stops on a halt instruction, and flags a memory timeout.

Parameters:
- WAIT_MAX, 15: maximum cycles spent in F or M without mem_ready before a timeout error; must be 1..255.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- run  input  1  start request; sampled only in IDLE.
- halt_req  input  1  decoder flag "instruction is HALT"; sampled only in R.
- need_mem  input  1  decoder flag "instruction uses the memory phase"; sampled only in X.
- mem_ready  input  1  memory acknowledge; sampled only in F and M.
- phase  output  5  one-hot phase, bit0=f, bit1=r, bit2=x, bit3=m, bit4=w; all zero in IDLE and HALT.
- ir_we  output  1  instruction-register load strobe.
- pc_we  output  1  PC update strobe.
- halted  output  1  sequencer stopped.
- err  output  1  memory timeout occurred.
- retired  output  CNT_W  count of completed instructions.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high; rst has priority over every other input in the same cycle.
- Reset values: state=IDLE, phase=5'b00000, ir_we=0, pc_we=0, halted=0, err=0, retired=0, wait counter=0.
- States: IDLE, F, R, X, M, W, HALT.
- phase output: registered and equal to the one-hot code of the current state. At most one bit is set at any time.
- IDLE: run=1 -> F on the next cycle; otherwise stay.
- F:
  - mem_ready=1 -> R next cycle, and ir_we=1 combinationally in that same cycle.
  - mem_ready=0 -> stay and increment the wait counter.
  - If the counter reaches WAIT_MAX while mem_ready=0 -> HALT with err=1.
- R: halt_req=1 -> HALT (err stays 0); else -> X. R always lasts exactly 1 cycle.
- X: need_mem=1 -> M; else -> W. X always lasts 1 cycle.
- M: same wait and timeout rules as F, but exit goes to W and ir_we stays 0.
- W:
  - pc_we=1 combinationally for this single cycle.
  - retired increments by 1, modulo 2^CNT_W, so the maximum value wraps to 0.
  - Next state is unconditionally F; run is not re-sampled.
- Wait counter: 8 bits, cleared on every entry to F or M. Timeout check: counter==WAIT_MAX-1 and mem_ready=0 -> HALT on the next edge. This means at most WAIT_MAX stalled cycles are observed before HALT.
- mem_ready=1 on the final permitted wait cycle: treated as success, not a timeout.
- HALT:
  - phase=0, halted=1, and err is held.
  - Only rst leaves HALT; run is ignored.
- Latency:
  - Non-memory instruction with zero waits: 4 cycles (F,R,X,W).
  - Memory instruction with zero waits: 5 cycles.
  - Each wait cycle adds 1.
- Inputs outside their sampling state are don't-care and must not affect state.
- Reset asserted mid-instruction in any state: next cycle is IDLE with all reset values. No pc_we or ir_we strobe is produced in the reset cycle.

Test Plan:
- Basic sequence: rst, then run=1 for 1 cycle, mem_ready=1, need_mem=0, halt_req=0 -> phase f,r,x,w,f,... (01,02,04,10,01 hex); pc_we high every 4th cycle; retired=3 after 3 instructions.
- Memory stall: need_mem=1, mem_ready low for 3 cycles in M -> phase 08 held 4 cycles, then 10; instruction takes 8 cycles; retired increments once.
- Halt: halt_req=1 in R -> next cycle phase=00, halted=1, err=0; run pulses and mem_ready toggling cause no change until rst.
- Timeout: WAIT_MAX=4, mem_ready=0 in F -> phase=01 for exactly 4 cycles, then halted=1, err=1. Separate run: mem_ready=1 on the 4th wait cycle -> R entered, err=0.
- Counter wrap: CNT_W=4, run 17 non-memory instructions -> retired reads 15 then 0 then 1.
- Reset mid-M: assert rst while phase=08 -> next cycle phase=00, retired=0, pc_we=0. A subsequent run restarts at F.
